usb_core_mailbox: RTL
=====================

Name: usb_core_mailbox

Overview:
Parametrised, buffered, bidirectional mailbox between the USB register block and the soft core's GPIO/flag bits. It replaces the single-byte, unbuffered USB↔core channel.
- Each direction has a FIFO of configurable width and depth.
- Transfers use a toggle ("flicker") handshake with per-transfer acknowledge toggles.
- Toggle inputs pass through configurable synchronisers.
- Sticky overflow/underflow status bits are provided.

Parameters:
pDATA_WIDTH, 8, payload width per transfer in both directions.
pDEPTH, 4, entries per FIFO; power of two, minimum 2.
pSYNC_STAGES, 2, synchroniser flops on each toggle input; minimum 1.
pCNT_WIDTH, $clog2(pDEPTH+1), width of the occupancy counts.

Ports:
clk  in  1  core clock; all logic on its rising edge.
reset_i  in  1  synchronous, active-high reset.
usb_wr_tgl_i  in  1  host toggles to push usb_wr_data_i toward the core.
usb_wr_data_i  in  pDATA_WIDTH  host→core payload; stable from toggle until ack.
usb_wr_ack_tgl_o  out  1  toggles once per handled host push.
usb_rd_tgl_i  in  1  host toggles to pop the core→host FIFO head.
usb_rd_data_o  out  pDATA_WIDTH  core→host FIFO head.
usb_rd_count_o  out  pCNT_WIDTH  core→host occupancy.
core_wr_tgl_i  in  1  core toggles to push core_wr_data_i toward the host.
core_wr_data_i  in  pDATA_WIDTH  core→host payload.
core_wr_ack_tgl_o  out  1  toggles once per handled core push.
core_rd_tgl_i  in  1  core toggles to pop the host→core FIFO head.
core_rd_data_o  out  pDATA_WIDTH  host→core FIFO head.
core_rd_count_o  out  pCNT_WIDTH  host→core occupancy.
status_clr_i  in  1  one-cycle pulse; clears all sticky flags.
status_o  out  4  {c2u_underflow, c2u_overflow, u2c_underflow, u2c_overflow}, sticky.

Behaviour:
- Reset:
  - FIFOs are emptied; counts read 0; data outputs read 0.
  - Ack toggles read 0; status_o reads 0.
  - Synchroniser flops and edge-history flops load 0.
- Reset mid-transfer:
  - Discards all buffered data.
  - Any toggle input held at 1 across reset produces exactly one event after reset deasserts. Senders must return toggles to 0 with reset.
- Event detection:
  - Each toggle input passes through a pSYNC_STAGES flop chain.
  - An event is the XOR of the last chain stage and a history flop.
  - An input change sampled at edge E produces an event acting at edge E+pSYNC_STAGES.
  - Events are level-free: each change of the toggle is exactly one event.
- Push:
  - On a write event, the payload (sampled directly at the acting edge) is written at the write pointer.
  - The count increments, and the matching ack toggle flips on the same edge.
- Push when full:
  - If a pop does not occur on the same edge, the data is dropped.
  - The overflow flag sets; the ack still toggles so the sender never deadlocks.
- Pop:
  - On a read event with count>0, the read pointer advances and the count decrements.
  - The data output shows the new head on the next cycle.
- Pop when empty: no pointer change; underflow flag sets.
- Head output: the data output always shows mem[rd_ptr], registered. Its value is don't-care-stable (the last value) when empty; the bench checks it only when count>0.
- Simultaneous push and pop, same FIFO, same edge:
  - Count unchanged when 0<count<pDEPTH.
  - When full: both are accepted, no overflow.
  - When empty: push accepted, pop flagged as underflow, count becomes 1.
- Pointers: log2(pDEPTH) bits, natural wrap-around. Full/empty are derived from the count.
- status_clr_i: clears the flags on the same edge. A flag-setting event on that edge wins; the flag reads 1.
- Independence: the two directions are fully independent; events in both directions on one edge are both processed.

Decomposition:
- Package usb_core_mailbox_pkg:
  - status bit index constants (U2C_OVF=0, U2C_UNF=1, C2U_OVF=2, C2U_UNF=3).
  - localparam helper for the pointer width.
- Sub-module mailbox_fifo:
  - Synchronous FIFO with push/pop/count/head, overflow and underflow pulses.
  - Instanced twice.
- The toggle synchroniser and edge detector are inline generate logic in the top.

Test Plan:
All scenarios use defaults: pDATA_WIDTH=8, pDEPTH=4, pSYNC_STAGES=2.
- Basic push: after reset, set usb_wr_data_i=8'hA5 and toggle usb_wr_tgl_i 0→1 (sampled at edge E) → at E+2, core_rd_count_o=1 and usb_wr_ack_tgl_o=1; next cycle core_rd_data_o=8'hA5. Toggling core_rd_tgl_i → count 0, status_o=0.
- Fill and overflow: core pushes 8'h01..8'h05 (five toggles) → core_wr_ack_tgl_o flips five times, usb_rd_count_o=4, status_o[2]=1. Host pops return 01,02,03,04 in order.
- Wrap-around: 10 push/pop pairs through host→core with data 8'h10..8'h19 → order preserved, count never exceeds 4, no status bits set.
- Simultaneous events: with FIFO full, align a push (8'hEE) and a pop on the same acting edge → count stays 4, no overflow, EE is later read last. With FIFO empty, align push and pop → count 1, status_o[1]=1.
- Underflow and clear: pop an empty core→host FIFO → status_o[3]=1. Pulse status_clr_i → 0. Pulse status_clr_i on the same edge as a new underflow → reads 1.
- Reset mid-operation: with 3 entries buffered and a toggle in flight, assert reset_i for 1 cycle with toggles returned to 0 → both counts 0, acks 0, status 0, and no spurious event afterwards.

Source files
------------

// File: rtl/usb_core_mailbox_pkg.sv
// usb_core_mailbox_pkg: shared status bit indices and sizing helper for the USB/core mailbox.
package usb_core_mailbox_pkg;
    localparam int U2C_OVF = 0;
    localparam int U2C_UNF = 1;
    localparam int C2U_OVF = 2;
    localparam int C2U_UNF = 3;
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/usb_core_mailbox_fifo.sv
// mailbox_fifo: synchronous FIFO with registered head and overflow/underflow pulses.
module mailbox_fifo
    import usb_core_mailbox_pkg::*;
#(
    parameter int pDATA_WIDTH = 8,
    parameter int pDEPTH      = 4,
    parameter int pCNT_WIDTH  = $clog2(pDEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [pDATA_WIDTH-1:0] data_i,
    output logic [pDATA_WIDTH-1:0] head_o,
    output logic [pCNT_WIDTH-1:0]  count_o,
    output logic                   ovf_o,
    output logic                   unf_o
);
    localparam int PW = ptr_width(pDEPTH);
    logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];
    logic [pDATA_WIDTH-1:0] head_q;
    logic [PW-1:0]          wr_q, rd_q;
    logic [pCNT_WIDTH-1:0]  cnt_q;
    logic                   full, do_pop, do_push;
    assign full    = cnt_q == pCNT_WIDTH'(pDEPTH);
    assign do_pop  = pop_i && cnt_q != '0;
    // a pop on the same edge frees the slot, so a full FIFO still accepts the push
    assign do_push = push_i && (!full || do_pop);
    assign ovf_o   = push_i && !do_push;
    assign unf_o   = pop_i && cnt_q == '0;
    assign head_o  = head_q;
    assign count_o = cnt_q;
    always_ff @(posedge clk) begin
        if (reset_i) begin
            mem_q  <= '{default: '0};
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= data_i;
            wr_q   <= wr_q + PW'(do_push);
            rd_q   <= rd_q + PW'(do_pop);
            cnt_q  <= cnt_q + pCNT_WIDTH'(do_push) - pCNT_WIDTH'(do_pop);
            head_q <= mem_q[rd_q];
        end
    end
endmodule

// File: rtl/usb_core_mailbox.sv
// usb_core_mailbox: buffered bidirectional toggle-handshake mailbox between USB registers and the core.
module usb_core_mailbox
    import usb_core_mailbox_pkg::*;
#(
    parameter int pDATA_WIDTH  = 8,
    parameter int pDEPTH       = 4,
    parameter int pSYNC_STAGES = 2,
    parameter int pCNT_WIDTH   = $clog2(pDEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   usb_wr_tgl_i,
    input  logic [pDATA_WIDTH-1:0] usb_wr_data_i,
    output logic                   usb_wr_ack_tgl_o,
    input  logic                   usb_rd_tgl_i,
    output logic [pDATA_WIDTH-1:0] usb_rd_data_o,
    output logic [pCNT_WIDTH-1:0]  usb_rd_count_o,
    input  logic                   core_wr_tgl_i,
    input  logic [pDATA_WIDTH-1:0] core_wr_data_i,
    output logic                   core_wr_ack_tgl_o,
    input  logic                   core_rd_tgl_i,
    output logic [pDATA_WIDTH-1:0] core_rd_data_o,
    output logic [pCNT_WIDTH-1:0]  core_rd_count_o,
    input  logic                   status_clr_i,
    output logic [3:0]             status_o
);
    logic [pSYNC_STAGES-1:0][3:0] sync_q;
    logic [pSYNC_STAGES:0][3:0]   chain;
    logic [3:0] hist_q, ev, flag, status_q;
    logic       usb_ack_q, core_ack_q;
    // bit order {core_rd, core_wr, usb_rd, usb_wr}; chain[0] is the raw input
    assign chain = {sync_q, core_rd_tgl_i, core_wr_tgl_i, usb_rd_tgl_i, usb_wr_tgl_i};
    assign ev    = sync_q[pSYNC_STAGES-1] ^ hist_q;
    always_ff @(posedge clk) begin
        if (reset_i) begin
            sync_q     <= '0;
            hist_q     <= '0;
            usb_ack_q  <= 1'b0;
            core_ack_q <= 1'b0;
            status_q   <= '0;
        end else begin
            sync_q     <= chain[pSYNC_STAGES-1:0];
            hist_q     <= sync_q[pSYNC_STAGES-1];
            usb_ack_q  <= usb_ack_q ^ ev[0];
            core_ack_q <= core_ack_q ^ ev[2];
            status_q   <= (status_q & {4{~status_clr_i}}) | flag;
        end
    end
    mailbox_fifo #(.pDATA_WIDTH(pDATA_WIDTH), .pDEPTH(pDEPTH), .pCNT_WIDTH(pCNT_WIDTH)) u_u2c (
        .clk(clk), .reset_i(reset_i), .push_i(ev[0]), .pop_i(ev[3]), .data_i(usb_wr_data_i),
        .head_o(core_rd_data_o), .count_o(core_rd_count_o), .ovf_o(flag[U2C_OVF]), .unf_o(flag[U2C_UNF])
    );
    mailbox_fifo #(.pDATA_WIDTH(pDATA_WIDTH), .pDEPTH(pDEPTH), .pCNT_WIDTH(pCNT_WIDTH)) u_c2u (
        .clk(clk), .reset_i(reset_i), .push_i(ev[2]), .pop_i(ev[1]), .data_i(core_wr_data_i),
        .head_o(usb_rd_data_o), .count_o(usb_rd_count_o), .ovf_o(flag[C2U_OVF]), .unf_o(flag[C2U_UNF])
    );
    assign usb_wr_ack_tgl_o  = usb_ack_q;
    assign core_wr_ack_tgl_o = core_ack_q;
    assign status_o          = status_q;
endmodule
